kfpga_config_loader: RTL and testbench

//   Upstream feeder of the FPGA core's config_in bus. Accepts the bitstream as a

---
 rtl/kfpga_config_loader_if.sv | 11 +
 rtl/kfpga_config_loader.sv | 147 ++++++++++++++
 tb/tb_kfpga_config_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kfpga_config_loader_if.sv
// Bitstream word handshake between a bitstream source and kfpga_config_loader.
interface kfpga_config_loader_if #(
    parameter int WORD_WIDTH = 32
) ();
    logic [WORD_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/kfpga_config_loader.sv
// Streams a bitstream into a shadow register, commits it atomically to config_out and
// releases core_nreset once a complete image is live. Optional CRC-32 check: CONFIG_CRC_EN.
module kfpga_config_loader #(
    parameter int CONFIG_WIDTH = 34688,
    parameter int WORD_WIDTH   = 32
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    kfpga_config_loader_if.slave    bus,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    core_nreset,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int NWORDS = CONFIG_WIDTH / WORD_WIDTH;
    localparam int CNT_W  = $clog2(NWORDS + 1);

`ifdef CONFIG_CRC_EN
    // The expected CRC travels as one extra word after the image.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS);
    localparam logic [31:0]      CRC_POLY = 32'h04C11DB7;
`else
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef CONFIG_CRC_EN
        ST_CHECK,
`endif
        ST_COMMIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        count;
    logic [CONFIG_WIDTH-1:0] shadow;
    logic                    accept;
    logic                    last_word;
    logic                    entering_load;
    logic                    busy_next;

    assign accept        = bus.data_valid & bus.data_ready;
    assign last_word     = accept && (count == LAST_IDX);
    assign entering_load = (state != ST_LOAD) && (next_state == ST_LOAD);

`ifdef CONFIG_CRC_EN
    logic [31:0] crc_acc;
    logic [31:0] crc_exp;
    logic        crc_match;
    logic        cfg_word;

    function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                             input logic [WORD_WIDTH-1:0] word);
        logic [31:0]           c;
        logic [WORD_WIDTH-1:0] w;
        logic                  fb;
        c = crc;
        w = word;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            fb = c[31] ^ w[WORD_WIDTH-1];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : '0);
            w  = w << 1;
        end
        return c;
    endfunction

    assign crc_match = (crc_acc == crc_exp);
    assign cfg_word  = (count != LAST_IDX);
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy_next  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) next_state = ST_LOAD;
`ifdef CONFIG_CRC_EN
            ST_LOAD:   if (last_word) next_state = ST_CHECK;
            ST_CHECK:  next_state = crc_match ? ST_COMMIT : ST_ERROR;
`else
            ST_LOAD:   if (last_word) next_state = ST_COMMIT;
`endif
            ST_COMMIT: next_state = ST_DONE;
            default:   next_state = ST_IDLE;
        endcase
        busy_next = (next_state == ST_LOAD) || (next_state == ST_COMMIT);
`ifdef CONFIG_CRC_EN
        busy_next = busy_next || (next_state == ST_CHECK);
`endif
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            config_out     <= '0;
            shadow         <= '0;
            count          <= '0;
            bus.data_ready <= 1'b0;
            core_nreset    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
`ifdef CONFIG_CRC_EN
            crc_acc        <= '1;
            crc_exp        <= '0;
`endif
        end else begin
            bus.data_ready <= (next_state == ST_LOAD);
            busy           <= busy_next;
            done           <= (next_state == ST_DONE);
            error          <= (next_state == ST_ERROR);
            // Release only after config_out has been stable for a full cycle in DONE.
            core_nreset    <= (state == ST_DONE) && (next_state == ST_DONE);

            if (entering_load) begin
                count   <= '0;
`ifdef CONFIG_CRC_EN
                crc_acc <= '1;
`endif
            end else if (accept) begin
                count <= count + CNT_W'(1);
`ifdef CONFIG_CRC_EN
                if (cfg_word) begin
                    shadow  <= {bus.data_in, shadow[CONFIG_WIDTH-1:WORD_WIDTH]};
                    crc_acc <= crc_step(crc_acc, bus.data_in);
                end else begin
                    crc_exp <= bus.data_in;
                end
`else
                shadow <= {bus.data_in, shadow[CONFIG_WIDTH-1:WORD_WIDTH]};
`endif
            end

            if (state == ST_COMMIT) config_out <= shadow;
        end
    end
endmodule

// File: tb/tb_kfpga_config_loader.sv
// Scoreboard bench for kfpga_config_loader at CONFIG_WIDTH=96, WORD_WIDTH=32.
module tb_kfpga_config_loader;
    localparam int CW = 96;
    localparam int WW = 32;
    localparam int NW = 3;
`ifdef CONFIG_CRC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clock;
    logic          nreset;
    logic          start;
    logic [CW-1:0] config_out;
    logic          core_nreset, busy, done, error;

    int errors = 0;
    int checks = 0;

    logic [WW-1:0] words [NW];
    logic [CW-1:0] exp_q [$];
    logic [CW-1:0] cur_img;

    kfpga_config_loader_if #(.WORD_WIDTH(WW)) bus ();

    kfpga_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
        .clock(clock), .nreset(nreset), .start(start), .bus(bus),
        .config_out(config_out), .core_nreset(core_nreset),
        .busy(busy), .done(done), .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] crc_model(input logic [CW-1:0] stream);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int b = CW - 1; b >= 0; b--) begin
            fb = c[31] ^ stream[b];
            c  = c << 1;
            if (fb) c = c ^ 32'h04C11DB7;
        end
        return c;
    endfunction

    task automatic set_words(input logic [WW-1:0] a, input logic [WW-1:0] b,
                             input logic [WW-1:0] c);
        words[0] = a;
        words[1] = b;
        words[2] = c;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (bus.data_ready !== 1'b1 || busy !== 1'b1 || core_nreset !== 1'b0) begin
            errors++;
            $display("FAIL start_enter_load: ready=%b busy=%b core_nreset=%b want 1 1 0",
                     bus.data_ready, busy, core_nreset);
        end
    endtask

    task automatic feed_word(input logic [WW-1:0] w, input int gap, input bit pulse_start);
        for (int g = 0; g < gap; g++) begin
            bus.data_valid = 1'b0;
            tick();
            checks++;
            if (bus.data_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_in_gap: got %b want 1", bus.data_ready);
            end
        end
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        start          = pulse_start;
        tick();
        start          = 1'b0;
        bus.data_valid = 1'b0;
    endtask

    task automatic load_stream(input int gap, input bit flip, input int pulse_idx);
        logic [31:0] crc;
        if (!flip) exp_q.push_back({words[2], words[1], words[0]});
        for (int k = 0; k < NW; k++)
            feed_word(words[k], (k == 0) ? 0 : gap, k == pulse_idx);
        crc = crc_model({words[0], words[1], words[2]});
`ifdef CONFIG_CRC_EN
        feed_word(crc ^ (flip ? 32'h0000_0100 : 32'h0), gap, 1'b0);
`endif
    endtask

    task automatic expect_done();
        int n;
        logic [CW-1:0] exp;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_early: got %b want 0", done);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL done_latency: got %0d want %0d", n, LAT);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
            exp = 'x;
        end else begin
            exp = exp_q.pop_front();
        end
        checks++;
        if (config_out !== exp) begin
            errors++;
            $display("FAIL image: got %h want %h", config_out, exp);
        end
        checks++;
        if (core_nreset !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL at_done: core_nreset=%b error=%b want 0 0", core_nreset, error);
        end
        tick();
        checks++;
        if (core_nreset !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release: core_nreset=%b done=%b busy=%b want 1 1 0",
                     core_nreset, done, busy);
        end
        cur_img = exp;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        tick();
        tick();
        checks++;
        if (config_out !== '0 || core_nreset !== 1'b0 || bus.data_ready !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: cfg=%h nrst=%b rdy=%b done=%b err=%b busy=%b want all 0",
                     config_out, core_nreset, bus.data_ready, done, error, busy);
        end
        nreset = 1'b1;
        tick();
        cur_img = '0;
    endtask

    task automatic test_back_to_back();
        set_words(32'h11111111, 32'h22222222, 32'h33333333);
        do_start();
        load_stream(0, 1'b0, -1);
        expect_done();
        checks++;
        if (config_out !== 96'h333333332222222211111111) begin
            errors++;
            $display("FAIL b2b_literal: got %h want 333333332222222211111111", config_out);
        end
    endtask

    task automatic test_idle_gaps();
        do_start();
        load_stream(5, 1'b0, -1);
        expect_done();
    endtask

    task automatic test_abort_and_reset();
        do_start();
        feed_word(32'hAAAAAAAA, 0, 1'b0);
        tick();
        checks++;
        if (config_out !== cur_img || core_nreset !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL partial_load: cfg=%h nrst=%b done=%b busy=%b want %h 0 0 1",
                     config_out, core_nreset, done, busy, cur_img);
        end
        #2 nreset = 1'b0;
        #2;
        checks++;
        if (config_out !== '0 || core_nreset !== 1'b0 || bus.data_ready !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cfg=%h nrst=%b rdy=%b done=%b err=%b busy=%b want all 0",
                     config_out, core_nreset, bus.data_ready, done, error, busy);
        end
        nreset = 1'b1;
        tick();
        set_words(32'h0BADF00D, 32'hC0FFEE00, 32'h12345678);
        do_start();
        load_stream(0, 1'b0, -1);
        expect_done();
    endtask

    task automatic test_start_ignored();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        tick();
        bus.data_in    = 32'hDEADBEEF;
        bus.data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.data_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: ready=%b busy=%b want 0 0", bus.data_ready, busy);
            end
        end
        start = 1'b1;
        tick();
        start          = 1'b0;
        bus.data_valid = 1'b0;
        set_words(32'hCAFEBABE, 32'h55AA55AA, 32'h0F0F0F0F);
        load_stream(1, 1'b0, 1);
        expect_done();
    endtask

    task automatic test_error_path();
`ifdef CONFIG_CRC_EN
        int n;
        logic [CW-1:0] old;
        set_words(32'hFEEDFACE, 32'h01234567, 32'h89ABCDEF);
        do_start();
        load_stream(0, 1'b0, -1);
        expect_done();
        old = cur_img;
        set_words(32'h13579BDF, 32'h2468ACE0, 32'hA5A5A5A5);
        do_start();
        load_stream(0, 1'b1, -1);
        n = 0;
        while (error !== 1'b1 && done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (error !== 1'b1 || n !== 1) begin
            errors++;
            $display("FAIL crc_error: error=%b after %0d cycles want 1 after 1", error, n);
        end
        tick();
        checks++;
        if (config_out !== old || core_nreset !== 1'b0 || done !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL error_hold: cfg=%h nrst=%b done=%b err=%b want %h 0 0 1",
                     config_out, core_nreset, done, error, old);
        end
`else
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_disabled: got %b want 0", error);
        end
`endif
    endtask

    initial begin
        nreset         = 1'b0;
        start          = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_idle_gaps();
        test_abort_and_reset();
        test_start_ignored();
        test_error_path();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
